// File: rtl/uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte-buffering front end for the transmit side of uart_top. A host pushes
// bytes over a valid/ready port into a DEPTH-entry FIFO. The feeder then hands
// them to uart_top one frame at a time on tx_start/tx_data. It uses uart_top's
// tx_done/tx_err (slow domain, resynchronised here) to mark frame completion.
// The feeder knows nothing about the frame format.
//
// Parameters
//   DEPTH       FIFO entries (power of 2, >= 2)
//   GAP_CYCLES  minimum clk cycles tx_start is held low between frames (>= 2)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   wr_valid   host byte valid
//   wr_data    host byte
//   wr_ready   FIFO can accept a byte (not full)
//   flush      one-cycle pulse: discard every queued, unsent byte
//   tx_start   to uart_top.tx_start, high for a whole frame
//   tx_data    to uart_top.tx_data, stable while tx_start is high
//   tx_done    from uart_top, frame finished (pulse or level)
//   tx_err     from uart_top, sampled together with tx_done
//   count      queued bytes, not counting the one in flight
//   empty      count == 0
//   busy       FSM is not idle
//   err_seen   sticky flag: some frame finished with tx_err set
//   err_count  (only with UART_FEEDER_ERRCNT_EN) saturating count of
//              frames that finished with tx_err set
//
// Build option
//   UART_FEEDER_ERRCNT_EN  adds the err_count output and its counter.
// ----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    input  logic                     tx_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     busy,
`ifdef UART_FEEDER_ERRCNT_EN
    output logic [7:0]               err_count,
`endif
    output logic                     err_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [GW-1:0] gap_cnt;

    logic done_meta;
    logic sync_done;
    logic sync_done_d;
    logic err_meta;
    logic sync_err;

    logic push;
    logic pop;
    logic done_rise;
    logic frame_end;
    logic gap_done;

    // wr_ready comes from the registered count, so the host sees no
    // combinational path from pop back to its handshake.
    assign wr_ready  = (count != FULL_COUNT);
    assign empty     = (count == '0);
    assign busy      = (state != S_IDLE);

    // flush beats a simultaneous write: that byte is dropped.
    assign push      = wr_valid && wr_ready && !flush;
    assign pop       = (state == S_IDLE) && !empty;
    assign done_rise = sync_done & ~sync_done_d;
    assign frame_end = (state == S_SEND) && done_rise;
    // A level-style tx_done must go low before the next frame starts.
    // Otherwise its rising edge could not be seen again.
    assign gap_done  = (gap_cnt >= GAP_LAST) && !sync_done;

    // Bring tx_done/tx_err in through two flops each. The third flop on
    // done gives the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_meta   <= 1'b0;
            sync_done   <= 1'b0;
            sync_done_d <= 1'b0;
            err_meta    <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            done_meta   <= tx_done;
            sync_done   <= done_meta;
            sync_done_d <= sync_done;
            err_meta    <= tx_err;
            sync_err    <= err_meta;
        end
    end

    // FIFO storage needs no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy. flush clears everything, even when the IDLE
    // pop fires in the same cycle; that popped byte is already on its way
    // into tx_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencing: IDLE -> SEND on a pop, SEND -> GAP on frame
    // completion, GAP -> IDLE after the inter-frame gap.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pop)       state_next = S_SEND;
            S_SEND:  if (done_rise) state_next = S_GAP;
            S_GAP:   if (gap_done)  state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_start rises together with the pop. It falls one clock after the
    // FSM leaves SEND. tx_data is loaded only on the pop, so it stays put
    // through SEND and GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= (state == S_SEND) || pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    // The gap counter restarts on every frame and saturates once the
    // minimum gap is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state != S_GAP) begin
            gap_cnt <= '0;
        end else if (gap_cnt < GAP_LAST) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // Only a completion seen in SEND counts. Stray done pulses elsewhere
    // are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_seen <= 1'b0;
        end else if (frame_end && sync_err) begin
            err_seen <= 1'b1;
        end
    end

`ifdef UART_FEEDER_ERRCNT_EN
    // Error frame counter: saturates at 255, cleared by flush as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (flush) begin
            err_count <= 8'd0;
        end else if (frame_end && sync_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
